riscv_muldiv: RTL and testbench
===============================

RISCV_MULDIV -- requirements
Module: riscv_muldiv

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning the operand/result width; legal values are 32 and 64.
REQ-002 The block SHALL have parameter MUL_STEP, default 1, meaning multiplier bits consumed per multiply cycle; legal values are 1, 2, 4 and 8.
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: a request is present.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block accepts a request this cycle.
REQ-007 The block SHALL have port in_funct3, input, 3 bits: 0 mul, 1 mulh, 2 mulhsu, 3 mulhu, 4 div, 5 divu, 6 rem, 7 remu.
REQ-008 The block SHALL have ports in_s1 and in_s2, input, XLEN bits each: rs1 (multiplicand/dividend) and rs2 (multiplier/divisor).
REQ-009 The block SHALL have port flush, input, 1 bit: abandon any operation in flight.
REQ-010 The block SHALL have port out_valid, output, 1 bit: out_result holds a finished result.
REQ-011 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-012 The block SHALL have port out_result, output, XLEN bits: the result, zero whenever out_valid=0.
REQ-013 The block SHALL have port busy, output, 1 bit: high in CALC or DONE.

Function
REQ-014 The block SHALL implement states IDLE, CALC and DONE; in_ready=1 only in IDLE.
REQ-015 An accept (in_valid & in_ready) SHALL latch funct3 and the operand magnitudes, the result sign (s1^s2 for mul/mulh/div; s1 sign for rem; s1 sign for mulhsu; 0 for unsigned ops) and enter CALC, or enter DONE directly on a fast path.
REQ-016 The fast paths SHALL go IDLE->DONE with latency 1: a multiply with either operand zero gives 0; divide-by-zero gives quotient all-ones and remainder = in_s1; signed overflow (s1 = most-negative, s2 = -1) gives div = in_s1, rem = 0.
REQ-017 A multiply SHALL add MUL_STEP partial products per CALC cycle to a 2*XLEN accumulator and finish on the cycle the remaining multiplier becomes zero (at most XLEN/MUL_STEP cycles).
REQ-018 A divide SHALL be restoring, one quotient bit per cycle, starting at the highest nonzero byte of the dividend magnitude (at most XLEN cycles).
REQ-019 The final CALC cycle SHALL apply the sign correction (two's-complement negate), select the low half (mul), high half (mulh*), quotient or remainder, register out_result and enter DONE.
REQ-020 Latency from the accept cycle to first out_valid SHALL be 1 + number of CALC cycles; the fast-path latency is 1.
REQ-021 In DONE, out_valid=1; out_result SHALL remain stable until out_valid & out_ready, which returns the block to IDLE on that edge.
REQ-022 flush SHALL return the block to IDLE on the next edge from any state, drop out_valid and discard the result, and SHALL win over a simultaneous accept or out_ready.
REQ-023 Operand inputs SHALL be ignored outside the accept cycle; changing them during CALC SHALL have no effect.
REQ-024 For mulhsu, only rs1 is treated as signed; for mulhu/divu/remu, neither operand is.

Reset
REQ-025 With reset high at an edge, the block SHALL enter IDLE with out_valid=0, out_result=0 and busy=0; reset SHALL take priority over flush, accept and out_ready.
REQ-026 Reset asserted mid-CALC or in DONE SHALL discard the operation; the next accepted request SHALL produce a correct result.

Verification
REQ-027 With XLEN=32 and MUL_STEP=1, mul 7, 0xFFFFFFFD -> 0xFFFFFFEB; mulh with the same operands -> 0xFFFFFFFF; mulhu 0xFFFFFFFF, 0xFFFFFFFF -> 0xFFFFFFFE; mulhsu 0xFFFFFFFF, 0xFFFFFFFF -> 0xFFFFFFFF; mul 7, 3 -> out_valid 3 cycles after accept.
REQ-028 div 0xFFFFFFF9, 2 -> 0xFFFFFFFD; rem with the same operands -> 0xFFFFFFFF; divu 100, 7 -> 14; remu 100, 7 -> 2.
REQ-029 divu 5, 0 -> 0xFFFFFFFF and rem 5, 0 -> 5, each with latency 1; div 0x80000000, 0xFFFFFFFF -> 0x80000000 and rem -> 0; mul 0, 0x12345678 -> 0 with latency 1.
REQ-030 Hold out_ready low for 3 cycles in DONE -> out_result stable and in_ready=0 throughout; then out_ready=1 -> IDLE next edge.
REQ-031 Assert flush in the 2nd CALC cycle of divu 0xFFFFFFFF, 3 -> out_valid never rises and IDLE on the next edge; the next request, divu 9, 3, gives 3.
REQ-032 Assert reset mid-CALC -> IDLE with out_result=0; repeat REQ-027 with MUL_STEP=4 and XLEN=64, where mulhu all-ones, all-ones -> 0xFFFFFFFFFFFFFFFE.

Source files
------------

// File: rtl/riscv_muldiv.sv
// riscv_muldiv: RV32M/RV64M multiply/divide unit.
//   Multiply: shift-add, MUL_STEP multiplier bits per cycle, stops early when the
//   remaining multiplier is zero. Divide: restoring, one quotient bit per cycle,
//   starting at the highest nonzero byte of the dividend magnitude.
// Ports:
//   clock, reset            - rising-edge clock, synchronous active-high reset
//   in_valid/in_ready       - request handshake (ready only in IDLE)
//   in_funct3, in_s1, in_s2 - operation (M-extension funct3) and operands
//   flush                   - abandon any operation in flight
//   out_valid/out_ready     - result handshake; out_result is zero unless valid
//   busy                    - operation in CALC or DONE
module riscv_muldiv #(
    parameter int XLEN     = 32,
    parameter int MUL_STEP = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      in_funct3,
    input  logic [XLEN-1:0] in_s1,
    input  logic [XLEN-1:0] in_s2,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic            busy
);
    localparam int CW = $clog2(XLEN) + 1;
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state_q;
    logic [2:0]          funct_q;
    logic                neg_q;
    logic [2*XLEN-1:0]   acc_q, mcand_q;
    logic [XLEN-1:0]     opb_q;      // multiplier (shifted down) or divisor
    logic [XLEN-1:0]     dvd_q;      // dividend bits in, quotient bits out
    logic [XLEN-1:0]     rem_q;
    logic [CW-1:0]       cnt_q;
    logic                out_valid_q;
    logic [XLEN-1:0]     out_result_q;

    // ---------------- accept-cycle decode ----------------
    logic            s1_sgn, s2_sgn, neg_d, fast_d;
    logic [XLEN-1:0] a_mag, b_mag, fast_res_d, dvd_init;
    int              nbytes;

    always_comb begin
        s1_sgn = 1'b0;
        s2_sgn = 1'b0;
        case (in_funct3)
            3'd0, 3'd1, 3'd4, 3'd6: begin
                s1_sgn = in_s1[XLEN-1];
                s2_sgn = in_s2[XLEN-1];
            end
            3'd2:    s1_sgn = in_s1[XLEN-1];
            default: ;
        endcase
        a_mag = s1_sgn ? -in_s1 : in_s1;
        b_mag = s2_sgn ? -in_s2 : in_s2;
        // remainder takes the dividend's sign; everything else the product of signs
        neg_d = (in_funct3 == 3'd6) ? s1_sgn : (s1_sgn ^ s2_sgn);

        fast_d     = 1'b0;
        fast_res_d = '0;
        if (!in_funct3[2]) begin
            fast_d = (in_s1 == '0) || (in_s2 == '0);
        end else if (in_s2 == '0) begin
            fast_d     = 1'b1;
            fast_res_d = in_funct3[1] ? in_s1 : '1;
        end else if (!in_funct3[0] && in_s1 == SMIN && in_s2 == '1) begin
            fast_d     = 1'b1;
            fast_res_d = in_funct3[1] ? '0 : in_s1;
        end

        // skip leading zero bytes of the dividend (at least one byte processed)
        nbytes = 1;
        for (int i = 0; i < XLEN/8; i++)
            if (a_mag[8*i +: 8] != 8'd0) nbytes = i + 1;
        dvd_init = a_mag << (XLEN - 8*nbytes);
    end

    // ---------------- CALC-cycle datapath ----------------
    logic [2*XLEN-1:0] acc_d, prod;
    logic [XLEN-1:0]   opb_d, dvd_d, rem_d, qr, res_d;
    logic [XLEN:0]     rem_t, diff;
    logic              qbit, last;

    always_comb begin
        acc_d = acc_q;
        for (int i = 0; i < MUL_STEP; i++)
            if (opb_q[i]) acc_d = acc_d + (mcand_q << i);
        opb_d = opb_q >> MUL_STEP;

        rem_t = {rem_q, dvd_q[XLEN-1]};
        diff  = rem_t - {1'b0, opb_q};
        qbit  = ~diff[XLEN];           // no borrow: partial remainder >= divisor
        rem_d = qbit ? diff[XLEN-1:0] : rem_t[XLEN-1:0];
        dvd_d = {dvd_q[XLEN-2:0], qbit};

        last = funct_q[2] ? (cnt_q == CW'(1)) : (opb_d == '0);

        prod = neg_q ? -acc_d : acc_d;
        qr   = funct_q[1] ? rem_d : dvd_d;
        if (funct_q[2])          res_d = neg_q ? -qr : qr;
        else if (funct_q == 3'd0) res_d = prod[XLEN-1:0];
        else                     res_d = prod[2*XLEN-1:XLEN];
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            state_q      <= IDLE;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    funct_q <= in_funct3;
                    neg_q   <= neg_d;
                    acc_q   <= '0;
                    mcand_q <= {{XLEN{1'b0}}, a_mag};
                    opb_q   <= b_mag;
                    dvd_q   <= dvd_init;
                    rem_q   <= '0;
                    cnt_q   <= CW'(8*nbytes);
                    if (fast_d) begin
                        out_result_q <= fast_res_d;
                        out_valid_q  <= 1'b1;
                        state_q      <= DONE;
                    end else begin
                        state_q      <= CALC;
                    end
                end
                CALC: begin
                    if (funct_q[2]) begin
                        dvd_q <= dvd_d;
                        rem_q <= rem_d;
                        cnt_q <= cnt_q - CW'(1);
                    end else begin
                        acc_q   <= acc_d;
                        mcand_q <= mcand_q << MUL_STEP;
                        opb_q   <= opb_d;
                    end
                    if (last) begin
                        out_result_q <= res_d;
                        out_valid_q  <= 1'b1;
                        state_q      <= DONE;
                    end
                end
                DONE: if (out_ready) begin
                    out_result_q <= '0;
                    out_valid_q  <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign in_ready   = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed bench: DUT A is XLEN=32/MUL_STEP=1, DUT B is XLEN=64/MUL_STEP=4.
module tb_riscv_muldiv;
    logic clock = 1'b0;
    always #5 clock = ~clock;
    logic reset;

    logic        a_in_valid, a_in_ready, a_flush, a_out_valid, a_out_ready, a_busy;
    logic [2:0]  a_funct3;
    logic [31:0] a_s1, a_s2, a_res;

    logic        b_in_valid, b_in_ready, b_flush, b_out_valid, b_out_ready, b_busy;
    logic [2:0]  b_funct3;
    logic [63:0] b_s1, b_s2, b_res;

    int vectors = 0;
    int fails   = 0;

    riscv_muldiv #(.XLEN(32), .MUL_STEP(1)) dut_a (
        .clock(clock), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_funct3(a_funct3), .in_s1(a_s1), .in_s2(a_s2), .flush(a_flush),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_result(a_res), .busy(a_busy));

    riscv_muldiv #(.XLEN(64), .MUL_STEP(4)) dut_b (
        .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_funct3(b_funct3), .in_s1(b_s1), .in_s2(b_s2), .flush(b_flush),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_result(b_res), .busy(b_busy));

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one request on DUT A, check latency/result, optionally stall out_ready.
    task automatic run_a(input string tag, input logic [2:0] f, input logic [31:0] s1,
                         input logic [31:0] s2, input logic [31:0] exp, input int exp_lat,
                         input int hold);
        int lat;
        logic [31:0] held;
        a_funct3 = f; a_s1 = s1; a_s2 = s2; a_in_valid = 1'b1;
        @(posedge clock); #1;
        a_in_valid = 1'b0;
        a_s1 = $urandom; a_s2 = $urandom; a_funct3 = 3'($urandom);  // must be ignored
        lat = 1;
        while (a_out_valid !== 1'b1 && lat < 200) begin
            @(posedge clock); #1; lat++;
        end
        check({tag, ".valid"}, 64'(a_out_valid), 64'd1);
        check({tag, ".result"}, 64'(a_res), 64'(exp));
        if (exp_lat > 0) check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        held = a_res;
        for (int i = 0; i < hold; i++) begin
            @(posedge clock); #1;
            check({tag, ".hold_result"}, 64'(a_res), 64'(held));
            check({tag, ".hold_in_ready"}, 64'(a_in_ready), 64'd0);
        end
        a_out_ready = 1'b1;
        @(posedge clock); #1;
        a_out_ready = 1'b0;
        check({tag, ".idle_after"}, {62'd0, a_in_ready, a_out_valid}, 64'd2);
    endtask

    task automatic run_b(input string tag, input logic [2:0] f, input logic [63:0] s1,
                         input logic [63:0] s2, input logic [63:0] exp, input int exp_lat);
        int lat;
        b_funct3 = f; b_s1 = s1; b_s2 = s2; b_in_valid = 1'b1;
        @(posedge clock); #1;
        b_in_valid = 1'b0;
        b_s1 = {$urandom, $urandom};
        lat = 1;
        while (b_out_valid !== 1'b1 && lat < 200) begin
            @(posedge clock); #1; lat++;
        end
        check({tag, ".valid"}, 64'(b_out_valid), 64'd1);
        check({tag, ".result"}, b_res, exp);
        if (exp_lat > 0) check({tag, ".latency"}, 64'(lat), 64'(exp_lat));
        b_out_ready = 1'b1;
        @(posedge clock); #1;
        b_out_ready = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        a_in_valid = 0; a_flush = 0; a_out_ready = 0; a_funct3 = 0; a_s1 = 0; a_s2 = 0;
        b_in_valid = 0; b_flush = 0; b_out_ready = 0; b_funct3 = 0; b_s1 = 0; b_s2 = 0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        check("reset_a", {a_out_valid, a_busy, a_in_ready, 29'd0, a_res}, 64'h2000_0000_0000_0000);
        check("reset_b_res", b_res, 64'd0);
        check("reset_b_flags", {61'd0, b_out_valid, b_busy, b_in_ready}, 64'd1);

        // multiply
        run_a("mul_7_m3",    3'd0, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 3,  0);
        run_a("mulh_7_m3",   3'd1, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 3,  0);
        run_a("mulhu_ones",  3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 33, 0);
        run_a("mulhsu_ones", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 0);
        run_a("mul_7_3",     3'd0, 32'd7,        32'd3,        32'd21,       3,  0);
        // divide
        run_a("div_m7_2",    3'd4, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 9,  0);
        run_a("rem_m7_2",    3'd6, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 9,  0);
        run_a("divu_100_7",  3'd5, 32'd100,      32'd7,        32'd14,       9,  0);
        run_a("remu_100_7",  3'd7, 32'd100,      32'd7,        32'd2,        9,  0);
        // fast paths
        run_a("divu_5_0",    3'd5, 32'd5,        32'd0,        32'hFFFFFFFF, 1,  0);
        run_a("rem_5_0",     3'd6, 32'd5,        32'd0,        32'd5,        1,  0);
        run_a("div_ovf",     3'd4, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1,  0);
        run_a("rem_ovf",     3'd6, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1,  0);
        run_a("mul_zero",    3'd0, 32'd0,        32'h12345678, 32'd0,        1,  0);
        // output stall
        run_a("hold_mul",    3'd0, 32'd7,        32'd3,        32'd21,       3,  3);

        // flush in the 2nd CALC cycle
        a_funct3 = 3'd5; a_s1 = 32'hFFFFFFFF; a_s2 = 32'd3; a_in_valid = 1'b1;
        @(posedge clock); #1 a_in_valid = 1'b0;
        check("flush_calc1_valid", 64'(a_out_valid), 64'd0);
        @(posedge clock); #1 a_flush = 1'b1;
        check("flush_calc2_valid", 64'(a_out_valid), 64'd0);
        @(posedge clock); #1 a_flush = 1'b0;
        check("flush_idle", {60'd0, a_out_valid, a_busy, a_in_ready, |a_res}, 64'h2);
        repeat (40) begin
            @(posedge clock); #1;
            if (a_out_valid !== 1'b0) check("flush_no_valid", 64'(a_out_valid), 64'd0);
        end
        run_a("divu_9_3",    3'd5, 32'd9,        32'd3,        32'd3,        9,  0);

        // reset mid-CALC
        a_funct3 = 3'd5; a_s1 = 32'd100; a_s2 = 32'd7; a_in_valid = 1'b1;
        @(posedge clock); #1 a_in_valid = 1'b0;
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        check("rst_calc_state", {60'd0, a_out_valid, a_busy, a_in_ready, 1'b0}, 64'h2);
        check("rst_calc_res", 64'(a_res), 64'd0);
        run_a("post_rst_mul", 3'd0, 32'd7,       32'd3,        32'd21,       3,  0);

        // wide configuration
        run_b("b_mul_7_m3",   3'd0, 64'd7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 2);
        run_b("b_mulh_7_m3",  3'd1, 64'd7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFFF, 2);
        run_b("b_mulhu_ones", 3'd3, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
              64'hFFFFFFFFFFFFFFFE, 17);
        run_b("b_mulhsu_ones", 3'd2, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
              64'hFFFFFFFFFFFFFFFF, 17);
        run_b("b_mul_7_3",    3'd0, 64'd7, 64'd3, 64'd21, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
